// File: rtl/camera_pattern_gen.sv
// OV7670-style RGB565 test-pattern source (bars/gray/LFSR-or-bytecount/solid); CAMERA_PATTERN_LFSR_EN selects the LFSR.
// Latency: outputs registered 1 clock after counters; no backpressure (free-running pclk stream), CI answered same cycle.
module camera_pattern_gen #(
  parameter logic [7:0] customInstructionId = 8'd0,
  parameter int H_PIXELS    = 640,
  parameter int V_LINES     = 480,
  parameter int H_BLANK     = 144,
  parameter int VSYNC_LINES = 3,
  parameter int V_BACK      = 17,
  parameter int V_FRONT     = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ciStart,
  input  logic        ciCke,
  input  logic [7:0]  ciN,
  input  logic [31:0] ciValueA,
  input  logic [31:0] ciValueB,
  output logic        ciDone,
  output logic [31:0] ciResult,
  output logic        hsync,
  output logic        vsync,
  output logic [7:0]  camData,
  output logic [15:0] frameCount
);

  localparam int LINE_LEN = 2 * H_PIXELS + H_BLANK;
  localparam int ACT_B    = 2 * H_PIXELS;
  localparam int BAR_W    = H_PIXELS / 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_ACTIVE = 3'd3,
    ST_VFRONT = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [11:0] line_cnt_q, line_cnt_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  bar_pix_q, bar_pix_d;
  logic [2:0]  bar_idx_q, bar_idx_d;
  logic        run_q, hsync_q, vsync_q;
  logic [1:0]  pattern_q, pat_act_q;
  logic [15:0] solid_q;
  logic [7:0]  cam_q, cam_d;

  logic        is_my_ci, line_end, last_line, enter_vsync, frame_end;
  logic        active_byte, pixel_last;
  logic [2:0]  cmd;
  logic [7:0]  gray;
  logic [15:0] pixel;
  logic [7:0]  pix_byte;
  logic        unused_ci;

  assign is_my_ci  = ciStart & ciCke & (ciN == customInstructionId);
  assign cmd       = ciValueA[2:0];
  assign ciDone    = is_my_ci;
  assign unused_ci = ^{ciValueA[31:3], ciValueB[31:16]};

  always_comb begin
    ciResult = 32'd0;
    if (is_my_ci) begin
      case (cmd)
        3'd2:    ciResult = {13'd0, pat_act_q, run_q, 13'd0, state_q};
        3'd3:    ciResult = {16'd0, frame_cnt_q};
        default: ciResult = 32'd0;
      endcase
    end
  end

  assign line_end = (byte_cnt_q == 16'(LINE_LEN - 1));

  always_comb begin
    case (state_q)
      ST_VSYNC:  last_line = (line_cnt_q == 12'(VSYNC_LINES - 1));
      ST_VBACK:  last_line = (line_cnt_q == 12'(V_BACK - 1));
      ST_ACTIVE: last_line = (line_cnt_q == 12'(V_LINES - 1));
      ST_VFRONT: last_line = (line_cnt_q == 12'(V_FRONT - 1));
      default:   last_line = 1'b1;
    endcase
  end

  // Every state except IDLE advances only on the final clock of its final line period.
  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    line_cnt_d  = line_cnt_q;
    enter_vsync = 1'b0;
    frame_end   = 1'b0;
    if (state_q == ST_IDLE) begin
      byte_cnt_d = 16'd0;
      line_cnt_d = 12'd0;
      if (run_q) begin
        state_d     = ST_VSYNC;
        enter_vsync = 1'b1;
      end
    end else if (line_end) begin
      byte_cnt_d = 16'd0;
      if (last_line) begin
        line_cnt_d = 12'd0;
        case (state_q)
          ST_VSYNC:  state_d = ST_VBACK;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = ST_VFRONT;
          ST_VFRONT: begin
            frame_end = 1'b1;
            if (run_q) begin
              state_d     = ST_VSYNC;
              enter_vsync = 1'b1;
            end else begin
              state_d = ST_IDLE;
            end
          end
          default:   state_d = ST_IDLE;
        endcase
      end else begin
        line_cnt_d = line_cnt_q + 12'd1;
      end
    end else begin
      byte_cnt_d = byte_cnt_q + 16'd1;
    end
  end

  assign frame_cnt_d = frame_end ? frame_cnt_q + 16'd1 : frame_cnt_q;
  assign active_byte = (state_q == ST_ACTIVE) && (byte_cnt_q < 16'(ACT_B));
  assign pixel_last  = active_byte && byte_cnt_q[0];

  // Bar position tracked by counters so bar width needs no divider.
  always_comb begin
    bar_pix_d = bar_pix_q;
    bar_idx_d = bar_idx_q;
    if (!active_byte) begin
      bar_pix_d = 8'd0;
      bar_idx_d = 3'd0;
    end else if (pixel_last) begin
      if (bar_pix_q == 8'(BAR_W - 1)) begin
        bar_pix_d = 8'd0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_pix_d = bar_pix_q + 8'd1;
      end
    end
  end

  assign gray = byte_cnt_q[8:1] + frame_cnt_q[7:0];

`ifdef CAMERA_PATTERN_LFSR_EN
  logic [15:0] lfsr_q, lfsr_d;
  always_comb begin
    lfsr_d = lfsr_q;
    if (enter_vsync)
      lfsr_d = 16'hACE1;
    else if (pixel_last)
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) lfsr_q <= 16'd0;
    else       lfsr_q <= lfsr_d;
  end
`endif

  always_comb begin
    pixel = 16'h0000;
    case (pat_act_q)
      2'd0: begin
        case (bar_idx_q)
          3'd0:    pixel = 16'hFFFF;
          3'd1:    pixel = 16'hFFE0;
          3'd2:    pixel = 16'h07FF;
          3'd3:    pixel = 16'h07E0;
          3'd4:    pixel = 16'hF81F;
          3'd5:    pixel = 16'hF800;
          3'd6:    pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {gray[7:3], gray[7:2], gray[7:3]};
`ifdef CAMERA_PATTERN_LFSR_EN
      2'd2:    pixel = lfsr_q;
`endif
      2'd3:    pixel = solid_q;
      default: pixel = 16'h0000;
    endcase
    pix_byte = byte_cnt_q[0] ? pixel[7:0] : pixel[15:8];
`ifndef CAMERA_PATTERN_LFSR_EN
    if (pat_act_q == 2'd2) pix_byte = byte_cnt_q[7:0];
`endif
    cam_d = active_byte ? pix_byte : 8'd0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 16'd0;
      line_cnt_q  <= 12'd0;
      frame_cnt_q <= 16'd0;
      bar_pix_q   <= 8'd0;
      bar_idx_q   <= 3'd0;
      run_q       <= 1'b0;
      pattern_q   <= 2'd0;
      pat_act_q   <= 2'd0;
      solid_q     <= 16'h0000;
      hsync_q     <= 1'b0;
      vsync_q     <= 1'b0;
      cam_q       <= 8'd0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      line_cnt_q  <= line_cnt_d;
      frame_cnt_q <= frame_cnt_d;
      bar_pix_q   <= bar_pix_d;
      bar_idx_q   <= bar_idx_d;
      hsync_q     <= active_byte;
      vsync_q     <= (state_q == ST_VSYNC);
      cam_q       <= cam_d;
      if (enter_vsync) pat_act_q <= pattern_q;
      if (is_my_ci && cmd == 3'd0) begin
        run_q     <= ciValueB[0];
        pattern_q <= ciValueB[2:1];
      end
      if (is_my_ci && cmd == 3'd1) solid_q <= ciValueB[15:0];
    end
  end

  assign hsync      = hsync_q;
  assign vsync      = vsync_q;
  assign camData    = cam_q;
  assign frameCount = frame_cnt_q;

endmodule
